// File: rtl/forward_hazard_unit_if.sv
// Forwarding / hazard interface between the EX/ID pipeline stages and
// forward_hazard_unit.
//   master : pipeline side. Drives the ID/EX operand ids, the EX result and
//            control, and memory read data. Receives the forwarded values,
//            the selects and the stall controls.
//   slave  : forward_hazard_unit.
interface forward_hazard_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           if_id_instr;
  logic [4:0]            id_ex_rs;
  logic [4:0]            id_ex_rt;
  logic [4:0]            ex_dest;
  logic                  ex_reg_write;
  logic                  ex_mem_to_reg;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] mem_read_data;

  logic [DATA_WIDTH-1:0] ex_mem_alu_result;
  logic [4:0]            ex_mem_dest;
  logic                  ex_mem_reg_write;
  logic                  ex_mem_mem_to_reg;
  logic [DATA_WIDTH-1:0] mem_wb_write_back_result;
  logic [4:0]            mem_wb_dest;
  logic                  mem_wb_reg_write;
  logic [1:0]            Forward_A;
  logic [1:0]            Forward_B;
  logic                  stall;
  logic                  id_ex_flush;

  modport master (
    output if_id_instr, id_ex_rs, id_ex_rt, ex_dest, ex_reg_write,
           ex_mem_to_reg, alu_result, mem_read_data,
    input  ex_mem_alu_result, ex_mem_dest, ex_mem_reg_write, ex_mem_mem_to_reg,
           mem_wb_write_back_result, mem_wb_dest, mem_wb_reg_write,
           Forward_A, Forward_B, stall, id_ex_flush
  );

  modport slave (
    input  if_id_instr, id_ex_rs, id_ex_rt, ex_dest, ex_reg_write,
           ex_mem_to_reg, alu_result, mem_read_data,
    output ex_mem_alu_result, ex_mem_dest, ex_mem_reg_write, ex_mem_mem_to_reg,
           mem_wb_write_back_result, mem_wb_dest, mem_wb_reg_write,
           Forward_A, Forward_B, stall, id_ex_flush
  );
endinterface

// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding producer and load-use hazard unit.
// It owns the EX/MEM and MEM/WB result and destination registers and
// generates the operand-forward selects for EX. It also detects load-use
// hazards and holds PC/IF-ID while ID/EX is bubbled.
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high
//   bus   : forward_hazard_unit_if.slave (all data, control and forwarding signals)
// Forward select encoding: 00 = regfile, 01 = MEM/WB, 10 = EX/MEM.
module forward_hazard_unit #(
  parameter int DATA_WIDTH        = 32,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  forward_hazard_unit_if.slave bus
);

  typedef enum logic {IDLE, STALL} state_t;

  // Value loaded into the counter on hazard entry. The IDLE cycle that detects
  // the hazard is the first stall cycle, so STALL covers the remaining N-1.
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

  logic [DATA_WIDTH-1:0] ex_mem_alu_q, mem_wb_res_q;
  logic [4:0]            ex_mem_dest_q, mem_wb_dest_q;
  logic                  ex_mem_rw_q, ex_mem_m2r_q, mem_wb_rw_q;
  state_t                state;
  logic [2:0]            cnt;
  logic                  hazard;
  logic [1:0]            fwd_a, fwd_b;

  // Only the rs/rt fields of the ID instruction are used for hazard detection.
  logic unused_instr;
  assign unused_instr = ^{bus.if_id_instr[31:26], bus.if_id_instr[15:0]};

  assign hazard = bus.ex_reg_write && bus.ex_mem_to_reg && (bus.ex_dest != 5'd0) &&
                  ((bus.ex_dest == bus.if_id_instr[25:21]) ||
                   (bus.ex_dest == bus.if_id_instr[20:16]));

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_alu_q  <= '0;
      ex_mem_dest_q <= '0;
      ex_mem_rw_q   <= 1'b0;
      ex_mem_m2r_q  <= 1'b0;
      mem_wb_res_q  <= '0;
      mem_wb_dest_q <= '0;
      mem_wb_rw_q   <= 1'b0;
      state         <= IDLE;
      cnt           <= 3'd0;
    end else begin
      // Pipeline registers advance every cycle. During a stall, ID/EX carries
      // a bubble, so the values that advance are harmless.
      ex_mem_alu_q  <= bus.alu_result;
      ex_mem_dest_q <= bus.ex_dest;
      ex_mem_rw_q   <= bus.ex_reg_write;
      ex_mem_m2r_q  <= bus.ex_mem_to_reg;
      mem_wb_res_q  <= ex_mem_m2r_q ? bus.mem_read_data : ex_mem_alu_q;
      mem_wb_dest_q <= ex_mem_dest_q;
      mem_wb_rw_q   <= ex_mem_rw_q;

      case (state)
        IDLE: begin
          if (hazard && (LOAD_STALL_CYCLES > 1)) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end
        end
        STALL: begin
          // Leave as the counter reaches zero. The hazard is not re-checked
          // here because EX holds the bubble inserted on the first stall cycle.
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // A load in EX/MEM is not a forward source: its ALU result is an address.
  // Register 0 is never forwarded. EX/MEM (the younger result) wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    if (ex_mem_rw_q && !ex_mem_m2r_q && (ex_mem_dest_q != 5'd0) &&
        (ex_mem_dest_q == bus.id_ex_rs))
      fwd_a = 2'b10;
    else if (mem_wb_rw_q && (mem_wb_dest_q != 5'd0) && (mem_wb_dest_q == bus.id_ex_rs))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (ex_mem_rw_q && !ex_mem_m2r_q && (ex_mem_dest_q != 5'd0) &&
        (ex_mem_dest_q == bus.id_ex_rt))
      fwd_b = 2'b10;
    else if (mem_wb_rw_q && (mem_wb_dest_q != 5'd0) && (mem_wb_dest_q == bus.id_ex_rt))
      fwd_b = 2'b01;
  end

  assign bus.ex_mem_alu_result        = ex_mem_alu_q;
  assign bus.ex_mem_dest              = ex_mem_dest_q;
  assign bus.ex_mem_reg_write         = ex_mem_rw_q;
  assign bus.ex_mem_mem_to_reg        = ex_mem_m2r_q;
  assign bus.mem_wb_write_back_result = mem_wb_res_q;
  assign bus.mem_wb_dest              = mem_wb_dest_q;
  assign bus.mem_wb_reg_write         = mem_wb_rw_q;
  assign bus.Forward_A                = fwd_a;
  assign bus.Forward_B                = fwd_b;
  assign bus.stall                    = (state == STALL) || hazard;
  assign bus.id_ex_flush              = (state == STALL) || hazard;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit. Two instances share one stimulus
// stream: u1 uses LOAD_STALL_CYCLES=1 and u3 uses LOAD_STALL_CYCLES=3.
module tb_forward_hazard_unit;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic [31:0]   if_id_instr;
  logic [4:0]    id_ex_rs, id_ex_rt, ex_dest;
  logic          ex_reg_write, ex_mem_to_reg;
  logic [DW-1:0] alu_result, mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  forward_hazard_unit_if #(.DATA_WIDTH(DW)) b1 ();
  forward_hazard_unit_if #(.DATA_WIDTH(DW)) b3 ();

  assign b1.if_id_instr = if_id_instr;   assign b3.if_id_instr = if_id_instr;
  assign b1.id_ex_rs = id_ex_rs;         assign b3.id_ex_rs = id_ex_rs;
  assign b1.id_ex_rt = id_ex_rt;         assign b3.id_ex_rt = id_ex_rt;
  assign b1.ex_dest = ex_dest;           assign b3.ex_dest = ex_dest;
  assign b1.ex_reg_write = ex_reg_write; assign b3.ex_reg_write = ex_reg_write;
  assign b1.ex_mem_to_reg = ex_mem_to_reg; assign b3.ex_mem_to_reg = ex_mem_to_reg;
  assign b1.alu_result = alu_result;     assign b3.alu_result = alu_result;
  assign b1.mem_read_data = mem_read_data; assign b3.mem_read_data = mem_read_data;

  forward_hazard_unit #(.DATA_WIDTH(DW), .LOAD_STALL_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .bus(b1));
  forward_hazard_unit #(.DATA_WIDTH(DW), .LOAD_STALL_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .bus(b3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] d, input logic rw, input logic m2r,
                          input logic [DW-1:0] res);
    ex_dest = d; ex_reg_write = rw; ex_mem_to_reg = m2r; alu_result = res;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_ex(5'd7, 1'b1, 1'b0, 32'hDEADBEEF);
    id_ex_rs = 5'd7; id_ex_rt = 5'd7;
    tick(); tick();
    n_checks++;
    if (b1.ex_mem_alu_result !== 0 || b1.ex_mem_dest !== 0 || b1.ex_mem_reg_write !== 0 ||
        b1.ex_mem_mem_to_reg !== 0 || b1.mem_wb_write_back_result !== 0 ||
        b1.mem_wb_dest !== 0 || b1.mem_wb_reg_write !== 0) begin
      n_fail++;
      $display("FAIL reset_regs: ex_mem=%h/%0d/%b/%b mem_wb=%h/%0d/%b required all 0",
               b1.ex_mem_alu_result, b1.ex_mem_dest, b1.ex_mem_reg_write,
               b1.ex_mem_mem_to_reg, b1.mem_wb_write_back_result, b1.mem_wb_dest,
               b1.mem_wb_reg_write);
    end
    n_checks++;
    if (b1.Forward_A !== 2'b00 || b1.Forward_B !== 2'b00 || b1.stall !== 1'b0 ||
        b1.id_ex_flush !== 1'b0 || b3.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: FA=%b FB=%b stall=%b flush=%b stall3=%b required 00 00 0 0 0",
               b1.Forward_A, b1.Forward_B, b1.stall, b1.id_ex_flush, b3.stall);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (b1.ex_mem_alu_result !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL reset_release: ex_mem_alu_result=%h required deadbeef", b1.ex_mem_alu_result);
    end
  endtask

  task automatic test_ex_forward();
    id_ex_rs = 5'd0; id_ex_rt = 5'd0;
    drive_ex(5'd3, 1'b1, 1'b0, 32'h10);
    tick();
    drive_ex(5'd0, 1'b0, 1'b0, 32'h0);
    id_ex_rs = 5'd3; id_ex_rt = 5'd3;
    #1;
    n_checks++;
    if (b1.Forward_A !== 2'b10 || b1.Forward_B !== 2'b10 || b1.ex_mem_alu_result !== 32'h10) begin
      n_fail++;
      $display("FAIL ex_forward: FA=%b FB=%b res=%h required 10 10 00000010",
               b1.Forward_A, b1.Forward_B, b1.ex_mem_alu_result);
    end
  endtask

  task automatic test_back_to_back();
    id_ex_rs = 5'd0; id_ex_rt = 5'd0;
    drive_ex(5'd4, 1'b1, 1'b0, 32'h1);
    tick();
    drive_ex(5'd4, 1'b1, 1'b0, 32'h2);
    tick();
    drive_ex(5'd0, 1'b1, 1'b0, 32'h5);
    id_ex_rs = 5'd4;
    #1;
    n_checks++;
    if (b1.Forward_A !== 2'b10 || b1.ex_mem_alu_result !== 32'h2 ||
        b1.mem_wb_write_back_result !== 32'h1) begin
      n_fail++;
      $display("FAIL b2b_priority: FA=%b ex_mem=%h mem_wb=%h required 10 2 1",
               b1.Forward_A, b1.ex_mem_alu_result, b1.mem_wb_write_back_result);
    end
    tick();
    // EX/MEM now holds a write to $0 and MEM/WB holds $4 <- 2.
    n_checks++;
    if (b1.Forward_A !== 2'b01 || b1.mem_wb_write_back_result !== 32'h2) begin
      n_fail++;
      $display("FAIL memwb_forward: FA=%b mem_wb=%h required 01 2",
               b1.Forward_A, b1.mem_wb_write_back_result);
    end
    tick();
    // Both stages now hold writes to $0.
    id_ex_rs = 5'd0; id_ex_rt = 5'd0;
    #1;
    n_checks++;
    if (b1.Forward_A !== 2'b00 || b1.Forward_B !== 2'b00) begin
      n_fail++;
      $display("FAIL reg0_no_forward: FA=%b FB=%b required 00 00", b1.Forward_A, b1.Forward_B);
    end
  endtask

  task automatic test_no_hazard();
    // Non-load writer matching rt, and load to $0: neither may stall.
    if_id_instr = {6'd0, 5'd0, 5'd9, 16'd0};
    drive_ex(5'd9, 1'b1, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (b1.stall !== 1'b0 || b3.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL no_hazard_alu: stall1=%b stall3=%b required 0 0", b1.stall, b3.stall);
    end
    if_id_instr = 32'h0;
    drive_ex(5'd0, 1'b1, 1'b1, 32'h0);
    #1;
    n_checks++;
    if (b1.stall !== 1'b0 || b3.id_ex_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL no_hazard_r0: stall1=%b flush3=%b required 0 0", b1.stall, b3.id_ex_flush);
    end
    drive_ex(5'd0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
  endtask

  task automatic test_load_use();
    id_ex_rs = 5'd0; id_ex_rt = 5'd0;
    if_id_instr = {6'd0, 5'd0, 5'd5, 16'd0};
    drive_ex(5'd5, 1'b1, 1'b1, 32'h100);
    #1;
    n_checks++;
    if (b1.stall !== 1'b1 || b1.id_ex_flush !== 1'b1 || b3.stall !== 1'b1 || b3.id_ex_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL load_stall_c0: s1=%b f1=%b s3=%b f3=%b required 1 1 1 1",
               b1.stall, b1.id_ex_flush, b3.stall, b3.id_ex_flush);
    end
    tick();
    // Bubble in EX, load in EX/MEM, memory returns data this cycle.
    drive_ex(5'd0, 1'b0, 1'b0, 32'h0);
    mem_read_data = 32'hCAFE;
    id_ex_rs = 5'd5;
    #1;
    n_checks++;
    if (b1.stall !== 1'b0 || b3.stall !== 1'b1 || b3.id_ex_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL load_stall_c1: s1=%b s3=%b f3=%b required 0 1 1", b1.stall, b3.stall, b3.id_ex_flush);
    end
    n_checks++;
    if (b1.Forward_A === 2'b10 || b1.Forward_A !== 2'b00) begin
      n_fail++;
      $display("FAIL load_not_source: FA=%b required 00", b1.Forward_A);
    end
    tick();
    mem_read_data = 32'h0;
    id_ex_rt = 5'd5;
    #1;
    n_checks++;
    if (b3.stall !== 1'b1 || b1.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_stall_c2: s1=%b s3=%b required 0 1", b1.stall, b3.stall);
    end
    n_checks++;
    if (b1.mem_wb_write_back_result !== 32'hCAFE || b1.Forward_B !== 2'b01 ||
        b1.Forward_A !== 2'b01 || b3.mem_wb_write_back_result !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL load_writeback: wb=%h FB=%b FA=%b wb3=%h required cafe 01 01 cafe",
               b1.mem_wb_write_back_result, b1.Forward_B, b1.Forward_A, b3.mem_wb_write_back_result);
    end
    tick();
    n_checks++;
    if (b3.stall !== 1'b0 || b3.id_ex_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL load_stall_end: s3=%b f3=%b required 0 0", b3.stall, b3.id_ex_flush);
    end
  endtask

  task automatic test_reset_in_stall();
    id_ex_rs = 5'd0; id_ex_rt = 5'd0;
    if_id_instr = {6'd0, 5'd6, 5'd0, 16'd0};
    drive_ex(5'd6, 1'b1, 1'b1, 32'h200);
    tick();
    drive_ex(5'd0, 1'b0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (b3.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_hazard_stall: s3=%b required 1", b3.stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (b3.stall !== 1'b0 || b3.id_ex_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_stall: s3=%b f3=%b required 0 0", b3.stall, b3.id_ex_flush);
    end
    tick();
    n_checks++;
    if (b3.stall !== 1'b0 || b3.ex_mem_dest !== 5'd0) begin
      n_fail++;
      $display("FAIL after_reset_idle: s3=%b dest=%0d required 0 0", b3.stall, b3.ex_mem_dest);
    end
  endtask

  initial begin
    reset = 1'b1;
    if_id_instr = 32'h0;
    id_ex_rs = 5'd0; id_ex_rt = 5'd0;
    mem_read_data = '0;
    drive_ex(5'd0, 1'b0, 1'b0, '0);
    test_reset();
    test_ex_forward();
    test_back_to_back();
    test_no_hazard();
    test_load_use();
    test_reset_in_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
